redmule_tile_addr_sched: RTL and testbench

- Parametrised successor to the fixed three-counter X-operand address scheduler.
- Walks an N-dimensional tile loop nest: NumDims counters, each with a runtime iteration count and byte stride, plus a leftover length on the outermost dimension.
- Issues one tile descriptor (base address, length, last flag) per tile to a streamer source over a valid/ready handshake, then waits for the streamer's done before advancing.
- Sits between the RedMulE controller/config registers and any streamer source: X, W or the quantization-scale streams.

---
 rtl/redmule_tile_addr_sched.sv | 193 +++++++++++++++++++
 tb/tb_redmule_tile_addr_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tile_addr_sched.sv
// Tile address scheduler: walks an N-deep loop nest of (iteration count, byte stride)
// counters and hands one tile descriptor at a time to a streamer source.
module redmule_tile_addr_sched #(
  parameter int unsigned NumDims = 3,
  parameter int unsigned AddrW   = 32,
  parameter int unsigned CntW    = 16,
  parameter int unsigned LenW    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [AddrW-1:0]           base_addr_i,
  input  logic [NumDims*CntW-1:0]    iters_i,
  input  logic [NumDims*AddrW-1:0]   strides_i,
  input  logic [LenW-1:0]            full_len_i,
  input  logic [LenW-1:0]            lftovr_len_i,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [AddrW-1:0]           req_addr_o,
  output logic [LenW-1:0]            req_len_o,
  output logic                       req_last_o,
  input  logic                       done_i,
  output logic                       busy_o,
  output logic                       finished_o,
  output logic [CntW+NumDims-1:0]    tile_cnt_o,
  output logic [1:0]                 dbg_state_o
);

  // Handshake: a descriptor transfers on the cycle req_valid_o && req_ready_i;
  // once raised, req_valid_o and the descriptor stay put until that cycle.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_FINISH} state_e;

  localparam logic [CntW-1:0]         CntOne  = 1;
  localparam logic [CntW+NumDims-1:0] TileOne = 1;

  state_e r_state, w_state_nxt;

  logic [CntW-1:0]  r_iters_m1 [NumDims];
  logic [AddrW-1:0] r_strides  [NumDims];
  logic [CntW-1:0]  r_idx      [NumDims];
  logic [AddrW-1:0] r_off      [NumDims];
  logic [AddrW-1:0] r_base;
  logic [LenW-1:0]  r_full_len;
  logic [LenW-1:0]  r_lftovr_len;

  logic [AddrW-1:0]        r_addr;
  logic [LenW-1:0]         r_len;
  logic                    r_last;
  logic [CntW+NumDims-1:0] r_tile_cnt;

  logic [CntW-1:0]  w_in_iters_m1 [NumDims];
  logic [CntW-1:0]  w_nxt_idx     [NumDims];
  logic [AddrW-1:0] w_nxt_off     [NumDims];
  logic [CntW-1:0]  w_sel_idx     [NumDims];
  logic [AddrW-1:0] w_sel_off     [NumDims];
  logic [CntW-1:0]  w_sel_iters_m1[NumDims];
  logic [AddrW-1:0] w_d_addr;
  logic [LenW-1:0]  w_d_len;
  logic             w_d_last;
  logic             w_idle;

  assign w_idle = (r_state == S_IDLE);

  // Odometer advance; offsets track idx*stride by accumulation only.
  always_comb begin : advance
    logic carry;
    carry = 1'b1;
    for (int d = 0; d < NumDims; d++) begin
      w_in_iters_m1[d] = (iters_i[d*CntW +: CntW] == '0) ? '0
                                                          : iters_i[d*CntW +: CntW] - CntOne;
      w_nxt_idx[d] = r_idx[d];
      w_nxt_off[d] = r_off[d];
      if (carry) begin
        if (r_idx[d] == r_iters_m1[d]) begin
          w_nxt_idx[d] = '0;
          w_nxt_off[d] = '0;
        end else begin
          w_nxt_idx[d] = r_idx[d] + CntOne;
          w_nxt_off[d] = r_off[d] + r_strides[d];
          carry        = 1'b0;
        end
      end
    end
  end

  // Descriptor for the tile about to be issued: the first one straight from the
  // config inputs on start, later ones from the advanced counters.
  always_comb begin : descriptor
    logic [AddrW-1:0] addr;
    logic             last;
    addr = w_idle ? base_addr_i : r_base;
    last = 1'b1;
    for (int d = 0; d < NumDims; d++) begin
      w_sel_idx[d]      = w_idle ? '0 : w_nxt_idx[d];
      w_sel_off[d]      = w_idle ? '0 : w_nxt_off[d];
      w_sel_iters_m1[d] = w_idle ? w_in_iters_m1[d] : r_iters_m1[d];
      addr              = addr + w_sel_off[d];
      last              = last & (w_sel_idx[d] == w_sel_iters_m1[d]);
    end
    w_d_addr = addr;
    w_d_last = last;
    if (w_idle) begin
      w_d_len = ((w_sel_idx[NumDims-1] == w_sel_iters_m1[NumDims-1]) && (lftovr_len_i != '0))
                ? lftovr_len_i : full_len_i;
    end else begin
      w_d_len = ((w_sel_idx[NumDims-1] == w_sel_iters_m1[NumDims-1]) && (r_lftovr_len != '0))
                ? r_lftovr_len : r_full_len;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start_i) w_state_nxt = S_ISSUE;
      S_ISSUE:     if (req_ready_i) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (done_i) w_state_nxt = r_last ? S_FINISH : S_ISSUE;
      S_FINISH:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else if (clear_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < NumDims; d++) begin
        r_iters_m1[d] <= '0;
        r_strides[d]  <= '0;
        r_idx[d]      <= '0;
        r_off[d]      <= '0;
      end
      r_base       <= '0;
      r_full_len   <= '0;
      r_lftovr_len <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_last       <= 1'b0;
      r_tile_cnt   <= '0;
    end else if (clear_i) begin
      for (int d = 0; d < NumDims; d++) begin
        r_idx[d] <= '0;
        r_off[d] <= '0;
      end
      r_addr     <= '0;
      r_len      <= '0;
      r_last     <= 1'b0;
      r_tile_cnt <= '0;
    end else if (w_idle && start_i) begin
      for (int d = 0; d < NumDims; d++) begin
        r_iters_m1[d] <= w_in_iters_m1[d];
        r_strides[d]  <= strides_i[d*AddrW +: AddrW];
        r_idx[d]      <= '0;
        r_off[d]      <= '0;
      end
      r_base       <= base_addr_i;
      r_full_len   <= full_len_i;
      r_lftovr_len <= lftovr_len_i;
      r_addr       <= w_d_addr;
      r_len        <= w_d_len;
      r_last       <= w_d_last;
      r_tile_cnt   <= '0;
    end else if ((r_state == S_WAIT_DONE) && done_i) begin
      for (int d = 0; d < NumDims; d++) begin
        r_idx[d] <= w_nxt_idx[d];
        r_off[d] <= w_nxt_off[d];
      end
      r_addr     <= w_d_addr;
      r_len      <= w_d_len;
      r_last     <= w_d_last;
      r_tile_cnt <= r_tile_cnt + TileOne;
    end
  end

  assign req_valid_o = (r_state == S_ISSUE);
  assign req_addr_o  = r_addr;
  assign req_len_o   = r_len;
  assign req_last_o  = r_last;
  assign busy_o      = !w_idle;
  assign finished_o  = (r_state == S_FINISH);
  assign tile_cnt_o  = r_tile_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_redmule_tile_addr_sched.sv
// Directed bench for redmule_tile_addr_sched: hand-computed descriptor sequences,
// back-pressure, spurious done, mid-job clear and address wrap-around.
module tb_redmule_tile_addr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [47:0] iters_i = '0;
  logic [95:0] strides_i = '0;
  logic [7:0]  full_len_i = '0;
  logic [7:0]  lftovr_len_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [31:0] req_addr_o;
  logic [7:0]  req_len_o;
  logic        req_last_o;
  logic        done_i = 1'b0;
  logic        busy_o;
  logic        finished_o;
  logic [18:0] tile_cnt_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  redmule_tile_addr_sched dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .iters_i      (iters_i),
    .strides_i    (strides_i),
    .full_len_i   (full_len_i),
    .lftovr_len_i (lftovr_len_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_addr_o   (req_addr_o),
    .req_len_o    (req_len_o),
    .req_last_o   (req_last_o),
    .done_i       (done_i),
    .busy_o       (busy_o),
    .finished_o   (finished_o),
    .tile_cnt_o   (tile_cnt_o),
    .dbg_state_o  (dbg_state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] base, input logic [47:0] it, input logic [95:0] st,
                           input logic [7:0] full, input logic [7:0] lft);
    base_addr_i  = base;
    iters_i      = it;
    strides_i    = st;
    full_len_i   = full;
    lftovr_len_i = lft;
    start_i      = 1'b1;
    step();
    start_i      = 1'b0;
    // Scramble the live config so only the sampled copy can be in use.
    base_addr_i  = 32'hDEAD_BEE0;
    strides_i    = {3{32'h0000_0404}};
    full_len_i   = 8'hEE;
    lftovr_len_i = 8'h11;
    exp_cnt      = 0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic do_tile(input string tag, input logic [31:0] a, input logic [7:0] l,
                         input logic last, input int hold, input logic spurious);
    chk({tag, "_valid"}, req_valid_o, 1);
    chk({tag, "_addr"}, req_addr_o, a);
    chk({tag, "_len"}, req_len_o, l);
    chk({tag, "_last"}, req_last_o, last);
    for (int i = 0; i < hold; i++) begin
      done_i = spurious && (i == 2);
      step();
      chk({tag, "_hold_valid"}, req_valid_o, 1);
      chk({tag, "_hold_addr"}, req_addr_o, a);
      chk({tag, "_hold_len"}, req_len_o, l);
    end
    done_i = 1'b0;
    if (hold > 0) chk({tag, "_hold_cnt"}, tile_cnt_o, exp_cnt);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    chk({tag, "_wait_valid"}, req_valid_o, 0);
    step();
    chk({tag, "_wait_still"}, req_valid_o, 0);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    exp_cnt++;
    chk({tag, "_cnt"}, tile_cnt_o, exp_cnt);
  endtask

  task automatic chk_finish(input string tag, input int n);
    chk({tag, "_fin_pulse"}, finished_o, 1);
    chk({tag, "_fin_valid"}, req_valid_o, 0);
    chk({tag, "_fin_cnt"}, tile_cnt_o, n);
    step();
    chk({tag, "_fin_drop"}, finished_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  localparam logic [47:0] ItA  = {16'd2, 16'd1, 16'd2};
  localparam logic [95:0] StA  = {32'd256, 32'd0, 32'd16};
  localparam logic [47:0] ItB  = {16'd1, 16'd2, 16'd3};
  localparam logic [95:0] StB  = {32'd64, 32'd0, 32'd16};
  localparam logic [95:0] StW  = {32'd0, 32'd0, 32'h20};

  initial begin
    step();
    step();
    chk("rst_valid", req_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_finished", finished_o, 0);
    chk("rst_cnt", tile_cnt_o, 0);
    rst_n = 1'b1;
    step();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("idle_done_busy", busy_o, 0);
    chk("idle_done_cnt", tile_cnt_o, 0);

    // Basic walk, no leftover.
    start_job(32'h1000, ItA, StA, 8'd8, 8'd0);
    do_tile("a1", 32'h1000, 8'd8, 1'b0, 0, 1'b0);
    do_tile("a2", 32'h1010, 8'd8, 1'b0, 0, 1'b0);
    do_tile("a3", 32'h1100, 8'd8, 1'b0, 0, 1'b0);
    do_tile("a4", 32'h1110, 8'd8, 1'b1, 0, 1'b0);
    chk_finish("a", 4);

    // Leftover length on the outer dim; back-pressure with a spurious done.
    start_job(32'h1000, ItA, StA, 8'd8, 8'd3);
    do_tile("b1", 32'h1000, 8'd8, 1'b0, 0, 1'b0);
    do_tile("b2", 32'h1010, 8'd8, 1'b0, 5, 1'b1);
    do_tile("b3", 32'h1100, 8'd3, 1'b0, 0, 1'b0);
    do_tile("b4", 32'h1110, 8'd3, 1'b1, 0, 1'b0);
    chk_finish("b", 4);

    // W-reuse pattern: stride 0 on dim 1 repeats the inner sweep.
    start_job(32'h0, ItB, StB, 8'd8, 8'd0);
    do_tile("c1", 32'd0, 8'd8, 1'b0, 0, 1'b0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("c_start_ignored_cnt", tile_cnt_o, 1);
    do_tile("c2", 32'd16, 8'd8, 1'b0, 0, 1'b0);
    do_tile("c3", 32'd32, 8'd8, 1'b0, 0, 1'b0);
    do_tile("c4", 32'd0, 8'd8, 1'b0, 0, 1'b0);
    do_tile("c5", 32'd16, 8'd8, 1'b0, 0, 1'b0);
    do_tile("c6", 32'd32, 8'd8, 1'b1, 0, 1'b0);
    chk_finish("c", 6);

    // Clear during WAIT_DONE of tile 2, with done in the same cycle.
    start_job(32'h1000, ItA, StA, 8'd8, 8'd0);
    do_tile("d1", 32'h1000, 8'd8, 1'b0, 0, 1'b0);
    chk("d2_addr", req_addr_o, 32'h1010);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    clear_i = 1'b1;
    done_i  = 1'b1;
    step();
    clear_i = 1'b0;
    done_i  = 1'b0;
    chk("clr_busy", busy_o, 0);
    chk("clr_valid", req_valid_o, 0);
    chk("clr_finished", finished_o, 0);
    chk("clr_cnt", tile_cnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clr_no_finish", finished_o, 0);
    end
    start_job(32'h1000, ItA, StA, 8'd8, 8'd0);
    do_tile("e1", 32'h1000, 8'd8, 1'b0, 0, 1'b0);
    do_tile("e2", 32'h1010, 8'd8, 1'b0, 0, 1'b0);
    do_tile("e3", 32'h1100, 8'd8, 1'b0, 0, 1'b0);
    do_tile("e4", 32'h1110, 8'd8, 1'b1, 0, 1'b0);
    chk_finish("e", 4);

    // Zero iteration counts act as one; address wraps modulo 2^32.
    start_job(32'hFFFF_FFF0, 48'd0, StW, 8'd8, 8'd0);
    do_tile("f1", 32'hFFFF_FFF0, 8'd8, 1'b1, 0, 1'b0);
    chk_finish("f", 1);
    start_job(32'hFFFF_FFF0, {16'd0, 16'd0, 16'd2}, StW, 8'd8, 8'd0);
    do_tile("g1", 32'hFFFF_FFF0, 8'd8, 1'b0, 0, 1'b0);
    do_tile("g2", 32'h0000_0010, 8'd8, 1'b1, 0, 1'b0);
    chk_finish("g", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
